cordic_rot_scheduler: RTL and testbench

Sequences the pipelined CORDIC_LUTF rotator for the multi-mode APSK exhaustive demapper.
- Accepts one received symbol (x,y) with its modulation mode.
- Issues that symbol to the rotator once per candidate ring/phase step, one step per cycle. Each step drives the direction-bit code for that step from a programmable table.
- Aligns each rotated result with its step tag for the downstream distance/compare logic.

---
 rtl/cordic_sched_pkg.sv | 43 ++++
 rtl/cordic_angle_table.sv | 44 ++++
 rtl/cordic_rot_scheduler.sv | 166 ++++++++++++++++
 tb/tb_cordic_rot_scheduler.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_sched_pkg.sv
// Shared types and constants for the CORDIC rotation scheduler.
// Holds sample width, rotator latency, mode encodings, and the angle-code layout.
// Has no ports. The scheduler top and the angle table both import it.
package cordic_sched_pkg;

  localparam int WL         = 18;  // Q8.10 two's complement sample
  localparam int NMODE      = 4;
  localparam int NSTEP      = 8;
  localparam int CORDIC_LAT = 2;   // rotator issue-to-result latency

  typedef enum logic [1:0] {
    MODE_QPSK   = 2'd0,
    MODE_PSK8   = 2'd1,
    MODE_APSK16 = 2'd2,
    MODE_APSK32 = 2'd3
  } mode_e;

  // Bit positions of the fields inside the 9-bit angle code.
  localparam int ANG_W           = 9;
  localparam int ANG_PRE_ROT_BIT = 8;
  localparam int ANG_PRE_BIT     = 7;
  localparam int ANG_A_MSB       = 6;
  localparam int ANG_A_LSB       = 0;

  typedef struct packed {
    logic       pre_rot;
    logic       angle_pre;
    logic [6:0] a;          // a6..a0 direction bits
  } angle_code_t;

  // One tag per issued step. It travels alongside the rotator pipeline.
  typedef struct packed {
    logic       vld;
    logic [2:0] step;
    logic       last;
  } tag_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

endpackage

// File: rtl/cordic_angle_table.sv
// Register file that holds the per-mode/per-step angle codes and the per-mode step counts.
// Ports: clk/rst_n. A write port (i_we, i_sel, i_wr_mode, i_wr_step, i_wr_data) that writes synchronously.
//        Combinational read ports: angle code by {i_rd_mode, i_rd_step}, and step count by i_cnt_mode.
module cordic_angle_table
  import cordic_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic              i_sel,       // 0 = angle entry, 1 = count entry
  input  logic [1:0]        i_wr_mode,
  input  logic [2:0]        i_wr_step,
  input  logic [ANG_W-1:0]  i_wr_data,
  input  logic [1:0]        i_rd_mode,
  input  logic [2:0]        i_rd_step,
  output angle_code_t       o_code,
  input  logic [1:0]        i_cnt_mode,
  output logic [2:0]        o_cnt        // burst length minus one
);

  angle_code_t r_ang [NMODE][NSTEP];
  logic [2:0]  r_cnt [NMODE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < NMODE; m++) begin
        r_cnt[m] <= '0;
        for (int s = 0; s < NSTEP; s++) begin
          r_ang[m][s] <= '0;
        end
      end
    end else if (i_we) begin
      if (i_sel) begin
        r_cnt[i_wr_mode] <= i_wr_data[2:0];
      end else begin
        r_ang[i_wr_mode][i_wr_step] <= angle_code_t'(i_wr_data);
      end
    end
  end

  assign o_code = r_ang[i_rd_mode][i_rd_step];
  assign o_cnt  = r_cnt[i_cnt_mode];

endmodule

// File: rtl/cordic_rot_scheduler.sv
// Feeds one APSK symbol through the pipelined CORDIC rotator, issuing one table-driven step per cycle.
// Each rotated result is then re-aligned with its step tag.
// Ports: in_* symbol handshake; cfg_* table writes with a one-cycle ack; cor_* rotator drive and cor_x_o/cor_y_o results;
//        out_* tagged results (no backpressure); busy.
module cordic_rot_scheduler
  import cordic_sched_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WL-1:0] in_x,
  input  logic [WL-1:0] in_y,
  input  logic [1:0]    in_mode,
  input  logic          cfg_we,
  input  logic          cfg_sel,
  input  logic [1:0]    cfg_mode,
  input  logic [2:0]    cfg_step,
  input  logic [8:0]    cfg_data,
  output logic          cfg_ack,
  output logic          cor_en,
  output logic [WL-1:0] cor_x,
  output logic [WL-1:0] cor_y,
  output logic          cor_pre_rot,
  output logic          cor_angle_pre,
  output logic [6:0]    cor_angle,
  input  logic [WL-1:0] cor_x_o,
  input  logic [WL-1:0] cor_y_o,
  output logic          out_valid,
  output logic [WL-1:0] out_x,
  output logic [WL-1:0] out_y,
  output logic [2:0]    out_step,
  output logic          out_last,
  output logic          busy
);

  state_e        r_state, w_state_nxt;
  logic [WL-1:0] r_x, r_y;
  logic [1:0]    r_mode;
  logic [2:0]    r_step, w_step_nxt;
  logic [2:0]    r_len_m1;
  logic [2:0]    r_a_hi;      // a6..a4 of the previous cycle's step
  logic          r_cfg_ack;
  tag_t          r_tag [CORDIC_LAT];

  angle_code_t   w_code;
  logic [2:0]    w_cnt;
  logic          w_issue, w_last, w_accept, w_load, w_busy, w_cfg_wr;
  tag_t          w_tag_in;

  cordic_angle_table u_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_we       (w_cfg_wr),
    .i_sel      (cfg_sel),
    .i_wr_mode  (cfg_mode),
    .i_wr_step  (cfg_step),
    .i_wr_data  (cfg_data),
    .i_rd_mode  (r_mode),
    .i_rd_step  (r_step),
    .o_code     (w_code),
    .i_cnt_mode (in_mode),
    .o_cnt      (w_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_load      = 1'b0;
    w_issue     = (r_state == ST_ISSUE);
    w_last      = w_issue && (r_step == r_len_m1);
    // On the last step the next symbol may be taken, so bursts chain with no bubble.
    in_ready    = !w_issue || w_last;
    w_accept    = in_valid && in_ready;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_ISSUE;
          w_load      = 1'b1;
          w_step_nxt  = 3'd0;
        end
      end
      ST_ISSUE: begin
        if (w_last) begin
          if (w_accept) begin
            w_load     = 1'b1;
            w_step_nxt = 3'd0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_step_nxt = r_step + 3'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy = w_issue;
    for (int i = 0; i < CORDIC_LAT; i++) begin
      w_busy = w_busy | r_tag[i].vld;
    end
  end

  // A symbol accept takes priority over a table write. A write is also never
  // allowed under a burst that is still reading the table.
  assign w_cfg_wr = cfg_we && !w_busy && !w_accept;

  assign w_tag_in.vld  = w_issue;
  assign w_tag_in.step = w_issue ? r_step : 3'd0;
  assign w_tag_in.last = w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x       <= '0;
      r_y       <= '0;
      r_mode    <= '0;
      r_step    <= '0;
      r_len_m1  <= '0;
      r_a_hi    <= '0;
      r_cfg_ack <= 1'b0;
      for (int i = 0; i < CORDIC_LAT; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      r_step    <= w_step_nxt;
      r_cfg_ack <= w_cfg_wr;
      if (w_load) begin
        r_x      <= in_x;
        r_y      <= in_y;
        r_mode   <= in_mode;
        r_len_m1 <= w_cnt;
      end
      // The rotator consumes a6..a4 one stage later than a3..a0, so these bits trail by one cycle.
      r_a_hi   <= w_issue ? w_code.a[6:4] : 3'd0;
      r_tag[0] <= w_tag_in;
      for (int i = 1; i < CORDIC_LAT; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  assign cor_en        = w_issue;
  assign cor_x         = w_issue ? r_x : '0;
  assign cor_y         = w_issue ? r_y : '0;
  assign cor_pre_rot   = w_issue & w_code.pre_rot;
  assign cor_angle_pre = w_issue & w_code.angle_pre;
  assign cor_angle     = {r_a_hi, (w_issue ? w_code.a[3:0] : 4'd0)};

  assign out_valid = r_tag[CORDIC_LAT-1].vld;
  assign out_step  = r_tag[CORDIC_LAT-1].step;
  assign out_last  = r_tag[CORDIC_LAT-1].last;
  // Results are masked outside tagged cycles, so stale rotator data never leaks out.
  assign out_x     = out_valid ? cor_x_o : '0;
  assign out_y     = out_valid ? cor_y_o : '0;

  assign busy    = w_busy;
  assign cfg_ack = r_cfg_ack;

endmodule

// File: tb/tb_cordic_rot_scheduler.sv
`timescale 1ns/1ps
module tb_cordic_rot_scheduler;
  import cordic_sched_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic [WL-1:0] in_x = '0, in_y = '0;
  logic [1:0]    in_mode = '0;
  logic          cfg_we = 1'b0, cfg_sel = 1'b0, cfg_ack;
  logic [1:0]    cfg_mode = '0;
  logic [2:0]    cfg_step = '0;
  logic [8:0]    cfg_data = '0;
  logic          cor_en, cor_pre_rot, cor_angle_pre;
  logic [WL-1:0] cor_x, cor_y, cor_x_o, cor_y_o;
  logic [6:0]    cor_angle;
  logic          out_valid, out_last, busy;
  logic [WL-1:0] out_x, out_y;
  logic [2:0]    out_step;

  always #5 clk = ~clk;

  cordic_rot_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y), .in_mode(in_mode),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_mode(cfg_mode), .cfg_step(cfg_step),
    .cfg_data(cfg_data), .cfg_ack(cfg_ack),
    .cor_en(cor_en), .cor_x(cor_x), .cor_y(cor_y), .cor_pre_rot(cor_pre_rot),
    .cor_angle_pre(cor_angle_pre), .cor_angle(cor_angle),
    .cor_x_o(cor_x_o), .cor_y_o(cor_y_o),
    .out_valid(out_valid), .out_x(out_x), .out_y(out_y), .out_step(out_step),
    .out_last(out_last), .busy(busy)
  );

  // Stand-in rotator: 2-cycle pipe. The x result folds in the step's low code bits,
  // so a misaligned tag would show up as a wrong x value.
  logic [WL-1:0] rx_p [2];
  logic [WL-1:0] ry_p [2];
  always @(posedge clk) begin
    rx_p[0] <= cor_x + WL'({cor_pre_rot, cor_angle_pre, cor_angle[3:0]});
    rx_p[1] <= rx_p[0];
    ry_p[0] <= cor_y ^ 18'h2AAAA;
    ry_p[1] <= ry_p[0];
  end
  assign cor_x_o = rx_p[1];
  assign cor_y_o = ry_p[1];

  typedef struct {
    logic [2:0]    step;
    logic          last;
    logic [WL-1:0] x;
    logic [WL-1:0] y;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         n_pass = 0;
  int         n_total = 0;
  logic [8:0] sh_ang [NMODE][NSTEP];
  logic [2:0] sh_cnt [NMODE];

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected: got out_step=%0d out_x=%h, required no output", out_step, out_x);
      end else begin
        mon_e = sb.pop_front();
        if (out_step !== mon_e.step || out_last !== mon_e.last || out_x !== mon_e.x || out_y !== mon_e.y)
          $display("FAIL sb_result: got step=%0d last=%0b x=%h y=%h, required step=%0d last=%0b x=%h y=%h",
                   out_step, out_last, out_x, out_y, mon_e.step, mon_e.last, mon_e.x, mon_e.y);
        else n_pass++;
      end
    end
  end

  task automatic clear_shadow();
    for (int m = 0; m < NMODE; m++) begin
      sh_cnt[m] = '0;
      for (int s = 0; s < NSTEP; s++) sh_ang[m][s] = '0;
    end
  endtask

  task automatic push_exp(input logic [WL-1:0] x, input logic [WL-1:0] y, input logic [1:0] m);
    exp_t e;
    for (int s = 0; s <= int'(sh_cnt[m]); s++) begin
      e.step = 3'(s);
      e.last = (s == int'(sh_cnt[m]));
      e.x    = x + WL'({sh_ang[m][s][8:7], sh_ang[m][s][3:0]});
      e.y    = y ^ 18'h2AAAA;
      sb.push_back(e);
    end
  endtask

  // Starts and ends on a negedge. Leaves in_valid high, so the caller decides whether to chain another symbol.
  task automatic send(input logic [WL-1:0] x, input logic [WL-1:0] y, input logic [1:0] m);
    int g = 0;
    in_valid = 1'b1; in_x = x; in_y = y; in_mode = m;
    while (in_ready !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL send_ready: got in_ready=%0b, required 1", in_ready);
    else begin
      n_pass++;
      push_exp(x, y, m);
    end
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic sel, input logic [1:0] m, input logic [2:0] s,
                           input logic [8:0] d, output logic ack);
    cfg_we = 1'b1; cfg_sel = sel; cfg_mode = m; cfg_step = s; cfg_data = d;
    @(negedge clk);
    ack = cfg_ack;
    cfg_we = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((busy !== 1'b0 || sb.size() != 0) && g < 100) begin
      @(negedge clk);
      g++;
    end
    n_total++;
    if (busy !== 1'b0 || sb.size() != 0)
      $display("FAIL wait_idle: got busy=%0b pending=%0d, required busy=0 pending=0", busy, sb.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_total++;
    if ({in_ready, cor_en, cfg_ack, busy, out_valid, out_last} !== 6'b100000)
      $display("FAIL reset_ctrl: got {rdy,en,ack,busy,ov,last}=%b, required 100000",
               {in_ready, cor_en, cfg_ack, busy, out_valid, out_last});
    else n_pass++;
    n_total++;
    if ({cor_x, cor_y, cor_angle, cor_pre_rot, cor_angle_pre, out_x, out_y, out_step} !== '0)
      $display("FAIL reset_data: got cor_x=%h cor_angle=%h out_x=%h, required 0", cor_x, cor_angle, out_x);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic ack;
    cfg_write(1'b1, 2'd0, 3'd0, 9'h000, ack);
    n_total++;
    if (ack !== 1'b1) $display("FAIL single_cnt_ack: got %0b, required 1", ack); else n_pass++;
    sh_cnt[0] = 3'd0;
    cfg_write(1'b0, 2'd0, 3'd0, 9'h17F, ack);
    n_total++;
    if (ack !== 1'b1) $display("FAIL single_ang_ack: got %0b, required 1", ack); else n_pass++;
    sh_ang[0][0] = 9'h17F;
    send(18'h00400, 18'h00200, 2'd0);
    in_valid = 1'b0;
    n_total++;
    if (cor_en !== 1'b1 || {cor_pre_rot, cor_angle_pre, cor_angle[3:0]} !== 6'b10_1111 ||
        cor_x !== 18'h00400 || cor_y !== 18'h00200 || in_ready !== 1'b1)
      $display("FAIL single_issue: got en=%0b pre=%0b ap=%0b a=%h x=%h y=%h rdy=%0b, required 1 1 0 F 00400 00200 1",
               cor_en, cor_pre_rot, cor_angle_pre, cor_angle[3:0], cor_x, cor_y, in_ready);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (cor_en !== 1'b0 || cor_angle[6:4] !== 3'b111 || in_ready !== 1'b1)
      $display("FAIL single_hi: got en=%0b a_hi=%b rdy=%0b, required 0 111 1", cor_en, cor_angle[6:4], in_ready);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (out_valid !== 1'b1 || out_last !== 1'b1 || out_step !== 3'd0 || in_ready !== 1'b1)
      $display("FAIL single_out: got ov=%0b last=%0b step=%0d rdy=%0b, required 1 1 0 1",
               out_valid, out_last, out_step, in_ready);
    else n_pass++;
    wait_idle();
  endtask

  task automatic test_long();
    logic ack, all_ack;
    logic [8:0] d;
    logic [2:0] prev_hi;
    cfg_write(1'b1, 2'd3, 3'd0, 9'd7, ack);
    all_ack = ack;
    sh_cnt[3] = 3'd7;
    for (int s = 0; s < 8; s++) begin
      d = 9'((s * 37 + 11) & 'h1FF);
      cfg_write(1'b0, 2'd3, 3'(s), d, ack);
      all_ack = all_ack & ack;
      sh_ang[3][s] = d;
    end
    n_total++;
    if (all_ack !== 1'b1) $display("FAIL long_cfg_ack: got %0b, required 1", all_ack); else n_pass++;
    send(18'h3F000, 18'h01234, 2'd3);
    in_valid = 1'b0;
    prev_hi = 3'd0;
    for (int s = 0; s < 8; s++) begin
      d = sh_ang[3][s];
      n_total++;
      if (cor_en !== 1'b1 || {cor_pre_rot, cor_angle_pre, cor_angle[3:0]} !== {d[8:7], d[3:0]} ||
          cor_angle[6:4] !== prev_hi || in_ready !== 1'(s == 7))
        $display("FAIL long_issue%0d: got en=%0b code=%b hi=%b rdy=%0b, required 1 %b %b %0b",
                 s, cor_en, {cor_pre_rot, cor_angle_pre, cor_angle[3:0]}, cor_angle[6:4], in_ready,
                 {d[8:7], d[3:0]}, prev_hi, (s == 7));
      else n_pass++;
      n_total++;
      if (s >= 2) begin
        if (out_valid !== 1'b1 || out_step !== 3'(s - 2))
          $display("FAIL long_out%0d: got ov=%0b step=%0d, required 1 %0d", s, out_valid, out_step, s - 2);
        else n_pass++;
      end else begin
        if (out_valid !== 1'b0) $display("FAIL long_out%0d: got ov=%0b, required 0", s, out_valid);
        else n_pass++;
      end
      prev_hi = d[6:4];
      @(negedge clk);
    end
    n_total++;
    if (cor_en !== 1'b0 || cor_angle[6:4] !== prev_hi || out_step !== 3'd6)
      $display("FAIL long_tail: got en=%0b hi=%b step=%0d, required 0 %b 6", cor_en, cor_angle[6:4], out_step, prev_hi);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (out_valid !== 1'b1 || out_step !== 3'd7 || out_last !== 1'b1 || busy !== 1'b1)
      $display("FAIL long_last: got ov=%0b step=%0d last=%0b busy=%0b, required 1 7 1 1",
               out_valid, out_step, out_last, busy);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0) $display("FAIL long_busy_fall: got busy=%0b, required 0", busy); else n_pass++;
    wait_idle();
  endtask

  task automatic test_back_to_back();
    logic ack, all_ack;
    int en_cnt = 0;
    cfg_write(1'b1, 2'd1, 3'd0, 9'd2, ack);
    all_ack = ack;
    sh_cnt[1] = 3'd2;
    cfg_write(1'b0, 2'd1, 3'd0, 9'h1A5, ack); all_ack = all_ack & ack; sh_ang[1][0] = 9'h1A5;
    cfg_write(1'b0, 2'd1, 3'd1, 9'h0C3, ack); all_ack = all_ack & ack; sh_ang[1][1] = 9'h0C3;
    cfg_write(1'b0, 2'd1, 3'd2, 9'h15A, ack); all_ack = all_ack & ack; sh_ang[1][2] = 9'h15A;
    n_total++;
    if (all_ack !== 1'b1) $display("FAIL b2b_cfg_ack: got %0b, required 1", all_ack); else n_pass++;
    send(18'h00111, 18'h3FF00, 2'd1);
    in_x = 18'h20000; in_y = 18'h00055; in_mode = 2'd1;
    for (int c = 0; c < 6; c++) begin
      n_total++;
      if (in_ready !== 1'((c == 2) || (c == 5)))
        $display("FAIL b2b_ready%0d: got %0b, required %0b", c, in_ready, ((c == 2) || (c == 5)));
      else n_pass++;
      if (c == 2) push_exp(18'h20000, 18'h00055, 2'd1);
      if (c == 3) begin
        in_valid = 1'b0;
        n_total++;
        if (cor_x !== 18'h20000 || cor_angle[6:4] !== 3'b101 || cor_angle[3:0] !== 4'h5)
          $display("FAIL b2b_boundary: got x=%h hi=%b lo=%h, required 20000 101 5",
                   cor_x, cor_angle[6:4], cor_angle[3:0]);
        else n_pass++;
      end
      en_cnt += int'(cor_en);
      @(negedge clk);
    end
    n_total++;
    if (en_cnt != 6 || cor_en !== 1'b0)
      $display("FAIL b2b_contig: got en_cycles=%0d en_after=%0b, required 6 0", en_cnt, cor_en);
    else n_pass++;
    wait_idle();
  endtask

  task automatic test_cfg_busy();
    logic ack;
    send(18'h00010, 18'h00020, 2'd3);
    in_valid = 1'b0;
    cfg_write(1'b0, 2'd0, 3'd0, 9'h0AB, ack);
    n_total++;
    if (ack !== 1'b0) $display("FAIL cfg_busy_ack: got %0b, required 0", ack); else n_pass++;
    wait_idle();
    send(18'h00001, 18'h00002, 2'd0);
    in_valid = 1'b0;
    n_total++;
    if ({cor_pre_rot, cor_angle_pre, cor_angle[3:0]} !== 6'b10_1111)
      $display("FAIL cfg_busy_unchanged: got %b, required 101111", {cor_pre_rot, cor_angle_pre, cor_angle[3:0]});
    else n_pass++;
    wait_idle();
    // Symbol accept and table write offered together: the accept wins.
    in_valid = 1'b1; in_x = 18'h00005; in_y = 18'h00006; in_mode = 2'd0;
    push_exp(18'h00005, 18'h00006, 2'd0);
    cfg_write(1'b0, 2'd0, 3'd0, 9'h0AB, ack);
    in_valid = 1'b0;
    n_total++;
    if (ack !== 1'b0) $display("FAIL cfg_vs_accept_ack: got %0b, required 0", ack); else n_pass++;
    wait_idle();
    cfg_write(1'b0, 2'd0, 3'd0, 9'h0AB, ack);
    n_total++;
    if (ack !== 1'b1) $display("FAIL cfg_idle_ack: got %0b, required 1", ack); else n_pass++;
    sh_ang[0][0] = 9'h0AB;
    send(18'h00003, 18'h00004, 2'd0);
    in_valid = 1'b0;
    n_total++;
    if ({cor_pre_rot, cor_angle_pre, cor_angle[3:0]} !== 6'b01_1011)
      $display("FAIL cfg_new_code: got %b, required 011011", {cor_pre_rot, cor_angle_pre, cor_angle[3:0]});
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (cor_angle[6:4] !== 3'b010) $display("FAIL cfg_new_hi: got %b, required 010", cor_angle[6:4]);
    else n_pass++;
    wait_idle();
  endtask

  task automatic test_reset_mid();
    send(18'h0ABCD, 18'h01111, 2'd3);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_total++;
    if (cor_en !== 1'b1) $display("FAIL rstmid_pre: got en=%0b, required 1", cor_en); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    clear_shadow();
    n_total++;
    if ({in_ready, cor_en, cfg_ack, busy, out_valid, out_last} !== 6'b100000 ||
        {cor_x, cor_y, cor_angle, cor_pre_rot, cor_angle_pre, out_x, out_y, out_step} !== '0)
      $display("FAIL rstmid_async: got {rdy,en,ack,busy,ov,last}=%b cor_x=%h cor_angle=%h, required 100000 0 0",
               {in_ready, cor_en, cfg_ack, busy, out_valid, out_last}, cor_x, cor_angle);
    else n_pass++;
    #1 rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_total++;
      if (out_valid !== 1'b0 || busy !== 1'b0)
        $display("FAIL rstmid_drop%0d: got ov=%0b busy=%0b, required 0 0", c, out_valid, busy);
      else n_pass++;
    end
    send(18'h00777, 18'h00888, 2'd3);
    in_valid = 1'b0;
    n_total++;
    if (in_ready !== 1'b1 || {cor_pre_rot, cor_angle_pre, cor_angle} !== 9'd0)
      $display("FAIL rstmid_table: got rdy=%0b code=%h, required 1 0", in_ready, {cor_pre_rot, cor_angle_pre, cor_angle});
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (cor_en !== 1'b0) $display("FAIL rstmid_len: got en=%0b, required 0", cor_en); else n_pass++;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clear_shadow();
    test_reset();
    test_single();
    test_long();
    test_back_to_back();
    test_cfg_busy();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
